// File: rtl/gameport_pkg.sv
// gameport_pkg
//   Shared types and constants for the analog game port sampler.
//   gp_state_t : sampler FSM states
//   CNT_MAX    : largest count step a measurement can reach (also the value
//                reported for an axis whose line never fell)
//   CENTRE     : count step that maps to a signed axis value of zero
//   to_signed8 : converts a 0..255 count step into a signed byte centred on 0

package gameport_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    MEAS,
    DONE,
    WAIT
  } gp_state_t;

  localparam logic [7:0] CNT_MAX = 8'hFF;
  localparam logic [7:0] CENTRE  = 8'h80;

  // Flipping the MSB is the same as subtracting 128 and reading the result
  // as two's complement: 0 -> -128, 128 -> 0, 255 -> +127.
  function automatic logic [7:0] to_signed8(input logic [7:0] step);
    return step ^ CENTRE;
  endfunction

endpackage

// File: rtl/gp_axis_timer.sv
// gp_axis_timer
//   Captures the count step at which one game port axis line first goes low.
//   Ports:
//     clk, reset_n : clock and asynchronous active-low reset
//     line_in      : synchronised axis line, high while the one-shot is timing
//     clear        : re-arms the timer for a new measurement
//     step         : current count step from the shared prescaler
//     latched      : 1 once the line has fallen since the last clear
//     value        : captured step, or CNT_MAX while nothing has been captured

module gp_axis_timer
  import gameport_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       line_in,
  input  logic       clear,
  input  logic [7:0] step,
  output logic       latched,
  output logic [7:0] value
);

  // Value defaults to CNT_MAX so an axis that never falls already reads as
  // full scale. Once latched, later rises and falls are ignored until clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      latched <= 1'b0;
      value   <= CNT_MAX;
    end else if (clear) begin
      latched <= 1'b0;
      value   <= CNT_MAX;
    end else if (!latched && !line_in) begin
      latched <= 1'b1;
      value   <= step;
    end
  end

endmodule

// File: rtl/gameport_axis_sampler.sv
// gameport_axis_sampler
//   Host-side reader for a PC/Tandy analog game port. Fires the one-shot
//   trigger, times the four axis lines until they fall, converts the widths
//   into signed joystick words, samples the buttons and repeats periodically.
//   Ports:
//     clk, reset_n : 50MHz clock, asynchronous active-low reset
//     en           : enables periodic sampling
//     gp_axis      : raw one-shot outputs {P2Y,P2X,P1Y,P1X}, asynchronous
//     gp_btn_n     : raw active-low buttons {P2B2,P2B1,P1B2,P1B1}, asynchronous
//     gp_trig      : one-shot trigger to the port, active high
//     joya0, joya1 : P1 and P2 {Y,X}, signed 8-bit each, 0 = centre
//     joy_btn      : pressed = 1, same order as gp_btn_n
//     timeout      : per axis, 1 = line never fell during the last sample
//     sample_vld   : one-cycle strobe when joya0/joya1/timeout update
//     busy         : high while triggering or measuring
//   Build option: define GP_DEBOUNCE_EN to debounce the buttons over
//   DEBOUNCE_CYC cycles; otherwise buttons follow the synchronised inputs.

module gameport_axis_sampler
  import gameport_pkg::*;
#(
`ifdef GP_DEBOUNCE_EN
  parameter int DEBOUNCE_CYC = 250000,
`endif
  parameter int TICK_DIV   = 265,
  parameter int TRIG_CYC   = 50,
  parameter int PERIOD_CYC = 833333
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  input  logic [3:0]  gp_axis,
  input  logic [3:0]  gp_btn_n,
  output logic        gp_trig,
  output logic [15:0] joya0,
  output logic [15:0] joya1,
  output logic [3:0]  joy_btn,
  output logic [3:0]  timeout,
  output logic        sample_vld,
  output logic        busy
);

  localparam int PSW = (TICK_DIV > 1)   ? $clog2(TICK_DIV)   : 1;
  localparam int TW  = (TRIG_CYC > 1)   ? $clog2(TRIG_CYC)   : 1;
  localparam int PDW = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;

  gp_state_t      state, next_state;
  logic [3:0]     axis_meta, axis_sync;
  logic [3:0]     btn_meta, btn_sync;
  logic [PSW-1:0] prescale;
  logic [7:0]     step;
  logic [TW-1:0]  trig_cnt;
  logic [PDW-1:0] period_cnt;
  logic           prescale_wrap;
  logic           period_end;
  logic           meas;
  logic [3:0]     latched;
  logic [7:0]     axis_val [4];

  // Both input groups are asynchronous to clk. Lines reset to their idle
  // (high) level so nothing is latched and no button reads pressed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      axis_meta <= 4'hF;
      axis_sync <= 4'hF;
      btn_meta  <= 4'hF;
      btn_sync  <= 4'hF;
    end else begin
      axis_meta <= gp_axis;
      axis_sync <= axis_meta;
      btn_meta  <= gp_btn_n;
      btn_sync  <= btn_meta;
    end
  end

  assign prescale_wrap = (prescale == PSW'(TICK_DIV - 1));
  assign period_end    = (period_cnt == PDW'(PERIOD_CYC - 1));
  assign meas          = (state == MEAS);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // A measurement ends when every axis has fallen, or after the full final
  // step has elapsed so that a line falling during step 255 still counts.
  // An en drop mid-sample is only looked at in WAIT, so the sample in
  // progress always completes and is reported.
  always_comb begin
    next_state = state;
    busy       = 1'b0;
    case (state)
      IDLE: if (en) next_state = TRIG;
      TRIG: begin
        busy = 1'b1;
        if (trig_cnt == TW'(TRIG_CYC - 1)) next_state = MEAS;
      end
      MEAS: begin
        busy = 1'b1;
        if (&latched || (step == CNT_MAX && prescale_wrap)) next_state = DONE;
      end
      DONE: next_state = WAIT;
      WAIT: if (period_end) next_state = en ? TRIG : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // gp_trig leaves the chip, so it comes straight from a flop rather than
  // from a state decode that could glitch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) gp_trig <= 1'b0;
    else          gp_trig <= (next_state == TRIG);
  end

  // Step/prescaler sit at zero outside MEAS so each measurement starts
  // clean. The period counter restarts on every TRIG entry and saturates.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      trig_cnt   <= '0;
      prescale   <= '0;
      step       <= '0;
      period_cnt <= '0;
    end else begin
      trig_cnt <= (state == TRIG) ? trig_cnt + TW'(1) : '0;
      if (state != MEAS) begin
        prescale <= '0;
        step     <= '0;
      end else if (prescale_wrap) begin
        prescale <= '0;
        if (step != CNT_MAX) step <= step + 8'd1;
      end else begin
        prescale <= prescale + PSW'(1);
      end
      if (next_state == TRIG && state != TRIG) period_cnt <= '0;
      else if (state != IDLE && !period_end)   period_cnt <= period_cnt + PDW'(1);
    end
  end

  // Outside MEAS each timer sees a forced-high line, so a line already low
  // during TRIG is captured as step 0 on the first measuring cycle.
  for (genvar i = 0; i < 4; i++) begin : g_axis
    gp_axis_timer u_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .line_in (axis_sync[i] | ~meas),
      .clear   (state == TRIG),
      .step    (step),
      .latched (latched[i]),
      .value   (axis_val[i])
    );
  end

  // Results are published together with the strobe, one cycle after DONE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      joya0      <= '0;
      joya1      <= '0;
      timeout    <= 4'hF;
      sample_vld <= 1'b0;
    end else if (state == DONE) begin
      joya0      <= {to_signed8(axis_val[1]), to_signed8(axis_val[0])};
      joya1      <= {to_signed8(axis_val[3]), to_signed8(axis_val[2])};
      timeout    <= ~latched;
      sample_vld <= 1'b1;
    end else begin
      sample_vld <= 1'b0;
    end
  end

`ifdef GP_DEBOUNCE_EN
  localparam int DW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  logic [DW-1:0] db_cnt [4];

  // The synced input is active low, so equality with the active-high output
  // means the two disagree and the stability counter should run.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      joy_btn <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (btn_sync[i] == joy_btn[i]) begin
          if (db_cnt[i] == DW'(DEBOUNCE_CYC - 1)) begin
            joy_btn[i] <= ~joy_btn[i];
            db_cnt[i]  <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + DW'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end
`else
  assign joy_btn = ~btn_sync;
`endif

endmodule
